// File: rtl/mem_responder.sv
// Wait-stated data-memory target for the MEM stage: latches a load/store request,
// holds ready low for WAIT_CYCLES busy cycles, then completes the access in DONE.
module mem_responder #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_r_en,
  input  logic        MEM_w_en,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_q, store_d;
  logic               load_q, load_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_out_q;
  logic [31:0]        mem_q [DEPTH];
  logic               access_c;
  logic               req_c;
  logic [31:0]        off_c;
  logic               in_range_c;
  logic               unused_off_bits;

  // Address decode: byte offset from the base, word index in off[31:2].
  assign req_c           = MEM_r_en | MEM_w_en;
  assign off_c           = address - 32'(ADDR_BASE);
  assign in_range_c      = (address >= 32'(ADDR_BASE)) && (off_c[31:2] < 30'(DEPTH));
  assign unused_off_bits = &off_c[1:0];

  assign ready    = ((state_q == IDLE) && !req_c) || (state_q == DONE);
  assign data_out = data_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      load_q  <= load_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; the access fires on the edge that enters DONE, using the _d
  // request fields so the zero-wait path sees the inputs sampled in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    load_d   = load_q;
    hit_d    = hit_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          store_d = MEM_w_en;
          load_d  = MEM_r_en & ~MEM_w_en;
          hit_d   = in_range_c;
          idx_d   = off_c[IDX_W+1:2];
          wdata_d = data_in;
          if (WAIT_CYCLES == 0) begin
            state_d  = DONE;
            access_c = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          access_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage and load result; reset clears every word and drops any in-flight write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_out_q <= '0;
    end else if (access_c) begin
      if (store_d && hit_d) mem_q[idx_d] <= wdata_d;
      if (load_d) data_out_q <= hit_d ? mem_q[idx_d] : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver queues expected completions,
// a negedge monitor checks data_out and latency whenever ready closes a request.
module tb_mem_responder;

  localparam int unsigned WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] addr, din, dout;
  logic        ready;
  logic        z_r_en, z_w_en;
  logic [31:0] z_addr, z_din, z_dout;
  logic        z_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dout;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   lat = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BASE(1024), .DEPTH(64), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .MEM_r_en(r_en), .MEM_w_en(w_en),
    .address(addr), .data_in(din), .data_out(dout), .ready(ready)
  );

  mem_responder #(.ADDR_BASE(1024), .DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .MEM_r_en(z_r_en), .MEM_w_en(z_w_en),
    .address(z_addr), .data_in(z_din), .data_out(z_dout), .ready(z_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: counts cycles of a pending request and scores it when ready rises.
  always @(negedge clk) begin
    if (!rst) begin
      lat = 0;
    end else if (r_en | w_en) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_dout"}, dout, mon_e.dout);
          check({mon_e.name, "_latency"}, 32'(lat), 32'(WAIT + 1));
        end
        lat = 0;
      end else begin
        lat++;
      end
    end
  end

  // Driver: called just after a rising edge; holds the request until ready.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_dout,
                        input string name);
    exp_t e;
    e.dout = exp_dout;
    e.name = name;
    exp_q.push_back(e);
    r_en = rd;
    w_en = wr;
    addr = a;
    din  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready) break;
      if (n == 49) check({name, "_timeout"}, 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    r_en = 1'b0;
    w_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    r_en = 1'b0; w_en = 1'b0; addr = '0; din = '0;
    z_r_en = 1'b0; z_w_en = 1'b0; z_addr = '0; z_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_dout", dout, 32'd0);
    end
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'd1024, 32'd0,         32'd0,         "ld_1024_after_reset");
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF,  32'd0,         "st_1032");
    access(1'b1, 1'b0, 32'd1032, 32'd0,         32'hDEADBEEF,  "ld_1032");
    access(1'b0, 1'b1, 32'd1020, 32'h12345678,  32'hDEADBEEF,  "st_oor_low");
    access(1'b0, 1'b1, 32'd1280, 32'h12345678,  32'hDEADBEEF,  "st_oor_high");
    access(1'b1, 1'b0, 32'd1020, 32'd0,         32'd0,         "ld_oor_low");
    access(1'b1, 1'b0, 32'd1280, 32'd0,         32'd0,         "ld_oor_high");
    access(1'b1, 1'b0, 32'd1024, 32'd0,         32'd0,         "ld_1024_no_alias");
    access(1'b1, 1'b0, 32'd1276, 32'd0,         32'd0,         "ld_1276_no_alias");
    access(1'b1, 1'b0, 32'd1032, 32'd0,         32'hDEADBEEF,  "ld_1032_intact");
    access(1'b1, 1'b1, 32'd1028, 32'h00000055,  32'hDEADBEEF,  "both_en_store");
    access(1'b1, 1'b0, 32'd1028, 32'd0,         32'h00000055,  "ld_1028");
    access(1'b1, 1'b0, 32'd1031, 32'd0,         32'h00000055,  "ld_1031_unaligned");

    // Reset in the middle of a store
    r_en = 1'b0; w_en = 1'b1; addr = 32'd1036; din = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready_req_high", 32'(ready), 32'd0);
    check("rst_dout_cleared", dout, 32'd0);
    w_en = 1'b0;
    #1;
    check("rst_ready_req_low", 32'(ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    access(1'b1, 1'b0, 32'd1036, 32'd0, 32'd0, "ld_1036_after_rst");
    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'd0, "ld_1028_cleared");

    // Zero-wait instance: complete in the cycle after the request appears
    @(posedge clk);
    #1;
    z_w_en = 1'b1; z_addr = 32'd1040; z_din = 32'hA5A5A5A5;
    @(negedge clk);
    check("zw_store_c0_ready", 32'(z_ready), 32'd0);
    @(negedge clk);
    check("zw_store_c1_ready", 32'(z_ready), 32'd1);
    @(posedge clk);
    #1;
    z_w_en = 1'b0; z_r_en = 1'b1;
    @(negedge clk);
    check("zw_load_c0_ready", 32'(z_ready), 32'd0);
    @(negedge clk);
    check("zw_load_c1_ready", 32'(z_ready), 32'd1);
    check("zw_load_c1_dout", z_dout, 32'hA5A5A5A5);
    @(posedge clk);
    #1 z_r_en = 1'b0;
    @(negedge clk);
    check("zw_idle_ready", 32'(z_ready), 32'd1);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
